hit_scorer_multi: RTL and testbench
===================================

// Module: hit_scorer_multi
// PURPOSE
//  Parametrised N-player bullet/player hit detector and scorer; successor of the 2-player detector.
//  Each frame_clk: axis-aligned box overlap of every live bullet against every other player,
//  single-credit arbitration, post-hit invulnerability window, saturating scores and win detection.
//  Sits between the bullet/player motion blocks and the score/HUD display logic.
// PARAMETERS
//  NUM_PLAYERS    2    players (= bullets, one per player), 2..8
//  COORD_W        10   coordinate/size width (unsigned screen coords)
//  SCORE_W        5    score counter width
//  WIN_SCORE      10   score that ends the game, 1..2^SCORE_W-1
//  INVULN_FRAMES  30   frames a hit player ignores further hits, 0 = none
// PORTS
//  frame_clk       in   1                   only clock; all state changes on posedge
//  Reset_n         in   1                   reset, asynchronous, active-low
//  PlayerX/PlayerY in   N*COORD_W           player centres, packed, player i at [i*COORD_W +: COORD_W]
//  Player_Size     in   COORD_W             player half-extent (shared)
//  BulletX/BulletY in   N*COORD_W           bullet centres; bullet i owned by player i
//  Bullet_Size     in   COORD_W             bullet half-extent (shared)
//  bullet_on       in   N                   bullet i live
//  round_restart   in   1                   sync clear of scores/timers, returns to PLAY
//  player_hit      out  N                   1-frame pulse: player i was hit this frame
//  bullet_consume  out  N                   1-frame pulse: bullet i scored, owner must despawn it
//  score           out  N*SCORE_W           score of player i (hits dealt)
//  invuln          out  N                   player i inside invulnerability window
//  game_over       out  1                   high in GAME_OVER state
//  winner_id       out  $clog2(N) (min 1)   valid while game_over
// BEHAVIOUR
//  Reset (Reset_n=0, async): all outputs 0, timers 0, state PLAY. Release is sampled on frame_clk.
//  Overlap(j->i): |BulletX[j]-PlayerX[i]| <= Player_Size+Bullet_Size AND same on Y; evaluated
//   in COORD_W+2-bit signed arithmetic; no unsigned wrap allowed at screen edges (coord 0).
//  Candidate(j->i): bullet_on[j] & Overlap & j!=i & invuln[i]==0 & state==PLAY.
//  Arbitration, same frame: bullet j hits only lowest-index candidate victim; victim i credits
//   only lowest-index shooter among those; others ignored (their bullets not consumed).
//  Hit j->i: player_hit[i]=1, bullet_consume[j]=1, score[j]+=1 saturating at 2^SCORE_W-1,
//   invuln timer[i] loaded with INVULN_FRAMES. Latency: outputs registered, 1 frame_clk after sample.
//  A bullet resting on a victim scores once: victim goes invuln; with INVULN_FRAMES=0 the
//   bullet_consume pulse is the only guard (re-scores each frame if owner ignores it).
//  Timers: decrement by 1 per frame to 0; invuln[i] = (timer[i]!=0). Hit on the frame a timer
//   reaches 0 is accepted (timer checked before decrement).
//  FSM: PLAY -> GAME_OVER when any updated score >= WIN_SCORE; simultaneous reach: lowest index
//   wins. GAME_OVER: no hits, scores frozen, timers still count down. round_restart (either
//   state) -> PLAY, scores/timers/pulses cleared next edge; round_restart has priority over hits.
//  Reset mid-frame: everything cleared immediately, no partial score update survives.
// STRUCTURE
//  Package hit_pkg: coord_t, score_t, player_id_t, typedef enum {PLAY, GAME_OVER} hit_state_e,
//   function aabb_overlap (signed widen + abs compare) shared with bullet/wall collision logic.
//  Sub-module hit_matrix: combinational N*N candidate matrix + priority arbitration, outputs
//   hit_victim[N], shooter_id[N]; top holds timers, scores, FSM, output registers.
// TESTING
//  1 N=2, P1 bullet at (100,100) on P2 at (104,100), sizes 8/2 -> next edge player_hit=2'b10,
//    bullet_consume=2'b01, score[0]=1, invuln[1]=1 for exactly 30 frames; bullet held -> no rescore.
//  2 Edge wrap: P2 at (3,3), size 8, bullet at (1020,1020) -> no hit; bullet at (0,0) -> hit.
//  3 N=4: bullets 1 and 3 both on P0 same frame -> only score[1]+=1, bullet_consume=4'b0010.
//  4 Score[0]=9, WIN_SCORE=10, hit -> score=10, game_over=1, winner_id=0; further overlaps ignored;
//    both P0 and P1 reach 10 same frame -> winner_id=0.
//  5 SCORE_W=3, WIN_SCORE=7 hold: saturation at 7, no wrap; round_restart with hit pending -> all 0.
//  6 Reset_n low mid-game between edges -> outputs 0 immediately, state PLAY after release.

Source files
------------

// File: rtl/hit_pkg.sv
// Shared types and geometry helper for the hit scoring logic.
package hit_pkg;

  // Widest coordinate any caller may pass; narrower coordinates are zero-extended.
  localparam int MAX_COORD_W = 16;
  localparam int MAX_PLAYERS = 8;

  typedef logic [MAX_COORD_W-1:0]         coord_t;
  typedef logic [7:0]                     score_t;
  typedef logic [$clog2(MAX_PLAYERS)-1:0] player_id_t;

  typedef enum logic {PLAY, GAME_OVER} hit_state_e;

  // Box overlap of two centred objects. Both centres are widened to signed
  // before subtracting, so an object at coord 0 and one near the far edge
  // never wrap into a false overlap.
  function automatic logic aabb_overlap(input coord_t ax, input coord_t ay,
                                        input coord_t bx, input coord_t by,
                                        input coord_t a_size, input coord_t b_size);
    logic signed [MAX_COORD_W+1:0] dx;
    logic signed [MAX_COORD_W+1:0] dy;
    logic signed [MAX_COORD_W+1:0] lim;
    dx  = $signed({2'b00, ax}) - $signed({2'b00, bx});
    dy  = $signed({2'b00, ay}) - $signed({2'b00, by});
    lim = $signed({2'b00, a_size}) + $signed({2'b00, b_size});
    if (dx < 0) dx = -dx;
    if (dy < 0) dy = -dy;
    return (dx <= lim) && (dy <= lim);
  endfunction

endpackage

// File: rtl/hit_matrix.sv
// Combinational bullet-vs-player candidate matrix with two-stage priority:
// each bullet picks its lowest-index victim, each victim credits its
// lowest-index shooter.
module hit_matrix
  import hit_pkg::*;
#(
  parameter int NUM_PLAYERS = 2,
  parameter int COORD_W     = 10,
  parameter int ID_W        = 1
) (
  input  logic [NUM_PLAYERS*COORD_W-1:0] player_x,
  input  logic [NUM_PLAYERS*COORD_W-1:0] player_y,
  input  logic [COORD_W-1:0]             player_size,
  input  logic [NUM_PLAYERS*COORD_W-1:0] bullet_x,
  input  logic [NUM_PLAYERS*COORD_W-1:0] bullet_y,
  input  logic [COORD_W-1:0]             bullet_size,
  input  logic [NUM_PLAYERS-1:0]         bullet_on,
  input  logic [NUM_PLAYERS-1:0]         invuln,
  input  logic                           enable,
  output logic [NUM_PLAYERS-1:0]         hit_victim,
  output logic [NUM_PLAYERS*ID_W-1:0]    shooter_id
);

  logic [NUM_PLAYERS-1:0] cand  [NUM_PLAYERS];  // cand[j][i]: bullet j could hit player i
  logic [NUM_PLAYERS-1:0] aim   [NUM_PLAYERS];  // aim[j]: one-hot chosen victim of bullet j
  logic [NUM_PLAYERS-1:0] col   [NUM_PLAYERS];  // col[i][j]: bullet j aims at player i
  logic [NUM_PLAYERS-1:0] first [NUM_PLAYERS];  // first[i]: one-hot credited shooter of player i

  // Build candidates, then isolate the lowest set bit per row and per column.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    hit_victim = '0;
    shooter_id = '0;
    for (int j = 0; j < NUM_PLAYERS; j++) begin
      cand[j] = '0;
      for (int i = 0; i < NUM_PLAYERS; i++) begin
        if (i != j) begin
          cand[j][i] = enable & bullet_on[j] & ~invuln[i] &
                       aabb_overlap(coord_t'(bullet_x[j*COORD_W +: COORD_W]),
                                    coord_t'(bullet_y[j*COORD_W +: COORD_W]),
                                    coord_t'(player_x[i*COORD_W +: COORD_W]),
                                    coord_t'(player_y[i*COORD_W +: COORD_W]),
                                    coord_t'(bullet_size), coord_t'(player_size));
        end
      end
      aim[j] = cand[j] & (~cand[j] + NUM_PLAYERS'(1));
    end
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      col[i] = '0;
      for (int j = 0; j < NUM_PLAYERS; j++) col[i][j] = aim[j][i];
      first[i]      = col[i] & (~col[i] + NUM_PLAYERS'(1));
      hit_victim[i] = |col[i];
      for (int j = 0; j < NUM_PLAYERS; j++) begin
        if (first[i][j]) shooter_id[i*ID_W +: ID_W] = ID_W'(j);
      end
    end
  end

endmodule

// File: rtl/hit_scorer_multi.sv
// N-player hit detector and scorer: invulnerability timers, saturating
// scores, PLAY/GAME_OVER control and registered hit/consume pulses.
module hit_scorer_multi
  import hit_pkg::*;
#(
  parameter int NUM_PLAYERS   = 2,
  parameter int COORD_W       = 10,
  parameter int SCORE_W       = 5,
  parameter int WIN_SCORE     = 10,
  parameter int INVULN_FRAMES = 30,
  localparam int ID_W         = (NUM_PLAYERS > 2) ? $clog2(NUM_PLAYERS) : 1
) (
  input  logic                           frame_clk,
  input  logic                           Reset_n,
  input  logic [NUM_PLAYERS*COORD_W-1:0] PlayerX,
  input  logic [NUM_PLAYERS*COORD_W-1:0] PlayerY,
  input  logic [COORD_W-1:0]             Player_Size,
  input  logic [NUM_PLAYERS*COORD_W-1:0] BulletX,
  input  logic [NUM_PLAYERS*COORD_W-1:0] BulletY,
  input  logic [COORD_W-1:0]             Bullet_Size,
  input  logic [NUM_PLAYERS-1:0]         bullet_on,
  input  logic                           round_restart,
  output logic [NUM_PLAYERS-1:0]         player_hit,
  output logic [NUM_PLAYERS-1:0]         bullet_consume,
  output logic [NUM_PLAYERS*SCORE_W-1:0] score,
  output logic [NUM_PLAYERS-1:0]         invuln,
  output logic                           game_over,
  output logic [ID_W-1:0]                winner_id
);

  localparam int TIMER_W = (INVULN_FRAMES > 0) ? $clog2(INVULN_FRAMES + 1) : 1;
  localparam logic [SCORE_W-1:0] SCORE_MAX  = '1;
  localparam logic [SCORE_W-1:0] WIN_LIMIT  = SCORE_W'(WIN_SCORE);
  localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(INVULN_FRAMES);

  hit_state_e             state_q, state_d;
  logic [ID_W-1:0]        winner_q, winner_d;
  logic [SCORE_W-1:0]     score_q [NUM_PLAYERS];
  logic [SCORE_W-1:0]     score_d [NUM_PLAYERS];
  logic [TIMER_W-1:0]     timer_q [NUM_PLAYERS];
  logic [TIMER_W-1:0]     timer_d [NUM_PLAYERS];
  logic [NUM_PLAYERS-1:0] hit_victim, consume_now, hit_d, consume_d;
  logic [NUM_PLAYERS*ID_W-1:0] shooter_id;

  hit_matrix #(
    .NUM_PLAYERS (NUM_PLAYERS),
    .COORD_W     (COORD_W),
    .ID_W        (ID_W)
  ) u_matrix (
    .player_x    (PlayerX),
    .player_y    (PlayerY),
    .player_size (Player_Size),
    .bullet_x    (BulletX),
    .bullet_y    (BulletY),
    .bullet_size (Bullet_Size),
    .bullet_on   (bullet_on),
    .invuln      (invuln),
    .enable      (state_q == PLAY),
    .hit_victim  (hit_victim),
    .shooter_id  (shooter_id)
  );

  // Present timers and scores, and turn per-victim shooter ids into per-bullet consume flags.
  always_comb begin
    score       = '0;
    invuln      = '0;
    consume_now = '0;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      invuln[i]                     = (timer_q[i] != '0);
      score[i*SCORE_W +: SCORE_W]   = score_q[i];
      for (int j = 0; j < NUM_PLAYERS; j++) begin
        if (hit_victim[i] && shooter_id[i*ID_W +: ID_W] == ID_W'(j)) consume_now[j] = 1'b1;
      end
    end
  end

  // Next state: timers, scores, win detection; restart overrides everything.
  always_comb begin
    state_d   = state_q;
    winner_d  = winner_q;
    hit_d     = hit_victim;
    consume_d = consume_now;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      score_d[i] = score_q[i];
      timer_d[i] = (timer_q[i] != '0) ? timer_q[i] - TIMER_W'(1) : '0;
      if (hit_victim[i]) timer_d[i] = TIMER_LOAD;
    end
    if (round_restart) begin
      state_d   = PLAY;
      winner_d  = '0;
      hit_d     = '0;
      consume_d = '0;
      for (int i = 0; i < NUM_PLAYERS; i++) begin
        score_d[i] = '0;
        timer_d[i] = '0;
      end
    end else if (state_q == PLAY) begin
      for (int j = 0; j < NUM_PLAYERS; j++) begin
        if (consume_now[j] && score_q[j] != SCORE_MAX) score_d[j] = score_q[j] + SCORE_W'(1);
      end
      // Descending scan so the lowest index reaching the limit wins a tie.
      for (int j = NUM_PLAYERS - 1; j >= 0; j--) begin
        if (score_d[j] >= WIN_LIMIT) begin
          state_d  = GAME_OVER;
          winner_d = ID_W'(j);
        end
      end
    end
  end

  // State and output registers.
  always_ff @(posedge frame_clk or negedge Reset_n) begin
    // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
    if (!Reset_n) begin
      state_q        <= PLAY;
      winner_q       <= '0;
      player_hit     <= '0;
      bullet_consume <= '0;
      // NOTE: the score and timer arrays are tiny register files that drive outputs, so they are reset.
      for (int i = 0; i < NUM_PLAYERS; i++) begin
        score_q[i] <= '0;
        timer_q[i] <= '0;
      end
    end else begin
      state_q        <= state_d;
      winner_q       <= winner_d;
      player_hit     <= hit_d;
      bullet_consume <= consume_d;
      for (int i = 0; i < NUM_PLAYERS; i++) begin
        score_q[i] <= score_d[i];
        timer_q[i] <= timer_d[i];
      end
    end
  end

  assign game_over = (state_q == GAME_OVER);
  assign winner_id = winner_q;

endmodule

// File: tb/tb_hit_scorer_multi.sv
// Self-checking bench for hit_scorer_multi (4 players): directed scenarios
// followed by randomized frames, all compared against a behavioural model.
module tb_hit_scorer_multi;

  localparam int N    = 4;
  localparam int CW   = 10;
  localparam int SW   = 5;
  localparam int WIN  = 10;
  localparam int INV  = 30;
  localparam int SMAX = (1 << SW) - 1;

  logic            frame_clk = 1'b0;
  logic            Reset_n;
  logic [N*CW-1:0] PlayerX, PlayerY, BulletX, BulletY;
  logic [CW-1:0]   Player_Size, Bullet_Size;
  logic [N-1:0]    bullet_on;
  logic            round_restart;
  logic [N-1:0]    player_hit, bullet_consume, invuln;
  logic [N*SW-1:0] score;
  logic            game_over;
  logic [1:0]      winner_id;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  int m_score [N];
  int m_timer [N];
  bit m_over;
  int m_win;

  hit_scorer_multi #(
    .NUM_PLAYERS   (N),
    .COORD_W       (CW),
    .SCORE_W       (SW),
    .WIN_SCORE     (WIN),
    .INVULN_FRAMES (INV)
  ) dut (
    .frame_clk      (frame_clk),
    .Reset_n        (Reset_n),
    .PlayerX        (PlayerX),
    .PlayerY        (PlayerY),
    .Player_Size    (Player_Size),
    .BulletX        (BulletX),
    .BulletY        (BulletY),
    .Bullet_Size    (Bullet_Size),
    .bullet_on      (bullet_on),
    .round_restart  (round_restart),
    .player_hit     (player_hit),
    .bullet_consume (bullet_consume),
    .score          (score),
    .invuln         (invuln),
    .game_over      (game_over),
    .winner_id      (winner_id)
  );

  always #5 frame_clk = ~frame_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit ovl(int j, int i);
    int dx, dy, lim;
    dx  = int'(BulletX[j*CW +: CW]) - int'(PlayerX[i*CW +: CW]);
    dy  = int'(BulletY[j*CW +: CW]) - int'(PlayerY[i*CW +: CW]);
    lim = int'(Player_Size) + int'(Bullet_Size);
    if (dx < 0) dx = -dx;
    if (dy < 0) dy = -dy;
    return (dx <= lim) && (dy <= lim);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < N; i++) begin
      m_score[i] = 0;
      m_timer[i] = 0;
    end
    m_over = 0;
    m_win  = 0;
  endtask

  // One frame: predict from current inputs, clock, compare, commit.
  task automatic step();
    int vic [N];
    int ns [N];
    int nt [N];
    logic [N-1:0]    eh, ec, ei;
    logic [N*SW-1:0] es;
    bit nover;
    int nwin;
    eh = '0; ec = '0; nover = m_over; nwin = m_win;
    for (int i = 0; i < N; i++) begin
      ns[i] = m_score[i];
      nt[i] = (m_timer[i] > 0) ? m_timer[i] - 1 : 0;
    end
    if (round_restart) begin
      for (int i = 0; i < N; i++) begin
        ns[i] = 0;
        nt[i] = 0;
      end
      nover = 0;
      nwin  = 0;
    end else if (!m_over) begin
      for (int j = 0; j < N; j++) begin
        vic[j] = -1;
        if (bullet_on[j])
          for (int i = 0; i < N; i++)
            if (vic[j] < 0 && i != j && m_timer[i] == 0 && ovl(j, i)) vic[j] = i;
      end
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++)
          if (vic[j] == i && !eh[i]) begin
            eh[i] = 1'b1;
            ec[j] = 1'b1;
            if (ns[j] < SMAX) ns[j]++;
            nt[i] = INV;
          end
      for (int j = 0; j < N; j++)
        if (!nover && ns[j] >= WIN) begin
          nover = 1;
          nwin  = j;
        end
    end
    @(posedge frame_clk);
    #1;
    for (int i = 0; i < N; i++) begin
      es[i*SW +: SW] = SW'(ns[i]);
      ei[i]          = (nt[i] != 0);
    end
    check("player_hit", 32'(player_hit), 32'(eh));
    check("bullet_consume", 32'(bullet_consume), 32'(ec));
    check("score", 32'(score), 32'(es));
    check("invuln", 32'(invuln), 32'(ei));
    check("game_over", 32'(game_over), 32'(nover));
    if (nover) check("winner_id", 32'(winner_id), 32'(nwin));
    for (int i = 0; i < N; i++) begin
      m_score[i] = ns[i];
      m_timer[i] = nt[i];
    end
    m_over = nover;
    m_win  = nwin;
  endtask

  task automatic set_far();
    for (int i = 0; i < N; i++) begin
      PlayerX[i*CW +: CW] = CW'(200 + 200 * i);
      PlayerY[i*CW +: CW] = CW'(500);
      BulletX[i*CW +: CW] = CW'(900);
      BulletY[i*CW +: CW] = CW'(100);
    end
    Player_Size   = CW'(8);
    Bullet_Size   = CW'(2);
    bullet_on     = '0;
    round_restart = 1'b0;
  endtask

  task automatic put_bullet(int j, int x, int y);
    BulletX[j*CW +: CW] = CW'(x);
    BulletY[j*CW +: CW] = CW'(y);
    bullet_on[j]        = 1'b1;
  endtask

  task automatic restart();
    round_restart = 1'b1;
    step();
    round_restart = 1'b0;
  endtask

  // Bullet 0 onto P2 and/or bullet 1 onto P3, then let the invulnerability expire.
  task automatic shoot(bit b0, bit b1, int idle);
    if (b0) put_bullet(0, 600, 500);
    if (b1) put_bullet(1, 800, 500);
    step();
    bullet_on = '0;
    repeat (idle) step();
  endtask

  function automatic logic [CW-1:0] rnd_coord();
    if ($urandom_range(0, 3) == 0) return CW'(1000 + $urandom_range(0, 23));
    return CW'($urandom_range(0, 40));
  endfunction

  initial begin
    int cnt;
    Reset_n = 1'b0;
    set_far();
    model_clear();
    #12;
    check("reset_hit", 32'(player_hit), 32'd0);
    check("reset_score", 32'(score), 32'd0);
    check("reset_over", 32'(game_over), 32'd0);
    Reset_n = 1'b1;

    // Single hit, invulnerability length, held bullet does not rescore
    put_bullet(0, 100, 100);
    PlayerX[1*CW +: CW] = CW'(104);
    PlayerY[1*CW +: CW] = CW'(100);
    step();
    check("t1_hit", 32'(player_hit), 32'b0010);
    check("t1_consume", 32'(bullet_consume), 32'b0001);
    check("t1_score0", 32'(score[0 +: SW]), 32'd1);
    cnt = invuln[1] ? 1 : 0;
    repeat (30) begin
      step();
      if (invuln[1]) cnt++;
    end
    check("t1_invuln_frames", 32'(cnt), 32'd30);
    check("t1_no_rescore", 32'(score[0 +: SW]), 32'd1);
    set_far();
    step();

    // Screen-edge wrap must not produce a hit
    restart();
    PlayerX[2*CW +: CW] = CW'(3);
    PlayerY[2*CW +: CW] = CW'(3);
    put_bullet(0, 1020, 1020);
    step();
    check("t2_no_wrap", 32'(player_hit), 32'd0);
    put_bullet(0, 0, 0);
    step();
    check("t2_edge_hit", 32'(player_hit), 32'b0100);
    set_far();
    step();

    // Two shooters on one victim: lowest shooter credited
    restart();
    PlayerX[0 +: CW] = CW'(50);
    PlayerY[0 +: CW] = CW'(50);
    put_bullet(1, 50, 50);
    put_bullet(3, 50, 50);
    step();
    check("t3_consume", 32'(bullet_consume), 32'b0010);
    check("t3_score1", 32'(score[1*SW +: SW]), 32'd1);
    check("t3_score3", 32'(score[3*SW +: SW]), 32'd0);
    set_far();
    step();

    // Win by P0 alone, then frozen scores
    restart();
    repeat (9) shoot(1, 1, 30);
    check("t4_pre0", 32'(score[0 +: SW]), 32'd9);
    check("t4_pre1", 32'(score[1*SW +: SW]), 32'd9);
    shoot(1, 0, 0);
    check("t4_over", 32'(game_over), 32'd1);
    check("t4_winner", 32'(winner_id), 32'd0);
    put_bullet(1, 800, 500);
    repeat (3) begin
      step();
      check("t4_frozen_hit", 32'(player_hit), 32'd0);
      check("t4_frozen_score1", 32'(score[1*SW +: SW]), 32'd9);
    end
    set_far();

    // Simultaneous win: lowest index
    restart();
    check("t4_restart_over", 32'(game_over), 32'd0);
    repeat (9) shoot(1, 1, 30);
    shoot(1, 1, 0);
    check("t4_tie_over", 32'(game_over), 32'd1);
    check("t4_tie_winner", 32'(winner_id), 32'd0);
    check("t4_tie_score1", 32'(score[1*SW +: SW]), 32'd10);

    // Restart has priority over a pending hit
    restart();
    put_bullet(0, 600, 500);
    round_restart = 1'b1;
    step();
    check("t5_restart_hit", 32'(player_hit), 32'd0);
    check("t5_restart_score", 32'(score), 32'd0);
    round_restart = 1'b0;
    step();
    set_far();

    // Asynchronous reset between edges
    #3;
    Reset_n = 1'b0;
    #1;
    check("t6_async_score", 32'(score), 32'd0);
    check("t6_async_invuln", 32'(invuln), 32'd0);
    model_clear();
    #2;
    Reset_n = 1'b1;
    step();

    // Randomized frames
    for (int k = 0; k < 1500; k++) begin
      for (int i = 0; i < N; i++) begin
        PlayerX[i*CW +: CW] = rnd_coord();
        PlayerY[i*CW +: CW] = rnd_coord();
        BulletX[i*CW +: CW] = rnd_coord();
        BulletY[i*CW +: CW] = rnd_coord();
      end
      Player_Size   = CW'($urandom_range(0, 6));
      Bullet_Size   = CW'($urandom_range(0, 6));
      bullet_on     = N'($urandom_range(0, (1 << N) - 1));
      round_restart = m_over ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 99) == 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
